// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus fabric.
// FSM state encoding, error read pattern, default region map.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  localparam int REGION_ROM = 0;
  localparam int REGION_RAM = 1;
  localparam int REGION_OUT = 2;

endpackage

// File: rtl/mmio_bus_fabric_if.sv
// CPU-side and slave-side signal bundle of the MMIO fabric.
// master: CPU + slaves view; slave: the fabric's own view.
interface mmio_bus_fabric_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NS = 4
) ();

  logic             cpu_re;
  logic             cpu_we;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic [DW-1:0]    cpu_rdata;
  logic             cpu_ready;
  logic             cpu_err;
  logic [NS-1:0]    s_nce;
  logic             s_re;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ack;

  modport master (
    output cpu_re, cpu_we,
    output cpu_addr, cpu_wdata,
    output s_rdata, s_ack,
    input  cpu_rdata, cpu_ready,
    input  cpu_err, s_nce,
    input  s_re, s_we,
    input  s_addr, s_wdata
  );

  modport slave (
    input  cpu_re, cpu_we,
    input  cpu_addr, cpu_wdata,
    input  s_rdata, s_ack,
    output cpu_rdata, cpu_ready,
    output cpu_err, s_nce,
    output s_re, s_we,
    output s_addr, s_wdata
  );

endinterface

// File: rtl/mmio_region_decode.sv
// Address select-field decoder: i_addr -> o_idx, o_mapped.
// o_mapped is low when the region index has no slave behind it.
module mmio_region_decode #(
  parameter int AW      = 32,
  parameter int NS      = 4,
  parameter int SEL_LSB = 11,
  parameter int SEL_W   = 3
) (
  input  logic [AW-1:0]    i_addr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_mapped
);

  logic w_unused;

  assign o_idx    = i_addr[SEL_LSB +: SEL_W];
  assign o_mapped = (int'(o_idx) < NS);
  assign w_unused = ^i_addr;

endmodule

// File: rtl/mmio_bus_fabric.sv
// MMIO fabric: CPU request -> one slave, wait/ack, rdata mux.
// Ports: clk, nrst (async low), bus (slave modport).
module mmio_bus_fabric
  import mmio_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            NS       = 4,
  parameter int            SEL_LSB  = 11,
  parameter int            SEL_W    = 3,
  parameter logic [4*NS-1:0] WAIT_CFG = '0,
  parameter logic [NS-1:0] ACK_MODE = '0,
  parameter logic [7:0]    TIMEOUT  = 8'd255,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input logic clk,
  input logic nrst,
  mmio_bus_fabric_if.slave bus
);

  state_e           r_state, w_state;
  logic [SEL_W-1:0] r_idx, w_idx_n;
  logic             r_rd, w_rd_n;
  logic             r_wr, w_wr_n;
  logic [3:0]       r_wait, w_wait_n;
  logic [7:0]       r_to, w_to_n;
  logic [AW-1:0]    r_addr, w_addr_n;
  logic [DW-1:0]    r_wdata, w_wdata_n;
  logic [DW-1:0]    r_rdata, w_rdata_n;
  logic [NS-1:0]    r_nce, w_nce_n;
  logic             r_sre, r_swe;
  logic             r_ready, r_err;

  logic [SEL_W-1:0] w_idx;
  logic             w_mapped;
  logic [3:0]       w_cfg_wait;
  logic             w_sel_ackm;
  logic             w_sel_ack;
  logic [DW-1:0]    w_sel_rdata;
  logic             w_req;
  logic             w_bad;

  mmio_region_decode #(
    .AW      (AW),
    .NS      (NS),
    .SEL_LSB (SEL_LSB),
    .SEL_W   (SEL_W)
  ) u_dec (
    .i_addr   (bus.cpu_addr),
    .o_idx    (w_idx),
    .o_mapped (w_mapped)
  );

  assign w_req = bus.cpu_re | bus.cpu_we;
  assign w_bad = !w_mapped
               | (bus.cpu_re & bus.cpu_we);

  // Wait count comes from the incoming index;
  // ack/rdata always from the latched one.
  always_comb begin
    w_cfg_wait  = '0;
    w_sel_ackm  = 1'b0;
    w_sel_ack   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (w_idx == SEL_W'(i))
        w_cfg_wait = WAIT_CFG[4*i +: 4];
      if (r_idx == SEL_W'(i)) begin
        w_sel_ackm  = ACK_MODE[i];
        w_sel_ack   = bus.s_ack[i];
        w_sel_rdata = bus.s_rdata[DW*i +: DW];
      end
    end
  end

  always_comb begin
    w_state   = r_state;
    w_idx_n   = r_idx;
    w_rd_n    = r_rd;
    w_wr_n    = r_wr;
    w_wait_n  = r_wait;
    w_to_n    = r_to;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_rdata_n = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_idx_n   = w_idx;
          w_rd_n    = bus.cpu_re;
          w_wr_n    = bus.cpu_we;
          w_addr_n  = bus.cpu_addr;
          w_wdata_n = bus.cpu_wdata;
          if (w_bad) begin
            w_state = ERR;
            if (bus.cpu_re)
              w_rdata_n = ERR_DATA;
          end else begin
            w_state  = ACCESS;
            w_wait_n = w_cfg_wait;
            w_to_n   = TIMEOUT;
          end
        end
      end
      ACCESS: begin
        if (!w_sel_ackm) begin
          if (r_wait == 4'd0) begin
            w_state = DONE;
            if (r_rd)
              w_rdata_n = w_sel_rdata;
          end else begin
            w_wait_n = r_wait - 4'd1;
          end
        end else if (w_sel_ack) begin
          // ack beats a same-cycle timeout
          w_state = DONE;
          if (r_rd)
            w_rdata_n = w_sel_rdata;
        end else if (r_to == 8'd0) begin
          w_state = ERR;
          if (r_rd)
            w_rdata_n = ERR_DATA;
        end else begin
          w_to_n = r_to - 8'd1;
        end
      end
      DONE:    w_state = IDLE;
      ERR:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_comb begin
    w_nce_n = '1;
    for (int i = 0; i < NS; i++)
      if (w_state == ACCESS
          && w_idx_n == SEL_W'(i))
        w_nce_n[i] = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wait  <= '0;
      r_to    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_nce   <= '1;
      r_sre   <= 1'b0;
      r_swe   <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx_n;
      r_rd    <= w_rd_n;
      r_wr    <= w_wr_n;
      r_wait  <= w_wait_n;
      r_to    <= w_to_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_rdata <= w_rdata_n;
      r_nce   <= w_nce_n;
      r_sre   <= (w_state == ACCESS) & w_rd_n;
      r_swe   <= (w_state == ACCESS) & w_wr_n;
      r_ready <= (w_state == DONE)
               | (w_state == ERR);
      r_err   <= (w_state == ERR);
    end
  end

  assign bus.s_nce     = r_nce;
  assign bus.s_re      = r_sre;
  assign bus.s_we      = r_swe;
  assign bus.s_addr    = r_addr;
  assign bus.s_wdata   = r_wdata;
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_ready = r_ready;
  assign bus.cpu_err   = r_err;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Bench for mmio_bus_fabric: per-cycle model compare
// plus literal latency/rdata checks.
module tb_mmio_bus_fabric;

  localparam logic [15:0] WCFG = 16'hF003;
  localparam logic [3:0]  ACKM = 4'b0100;
  localparam logic [7:0]  TMO  = 8'd10;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mmio_bus_fabric_if #(
    .AW(32), .DW(32), .NS(4)
  ) bus ();

  mmio_bus_fabric #(
    .AW       (32),
    .DW       (32),
    .NS       (4),
    .SEL_LSB  (11),
    .SEL_W    (3),
    .WAIT_CFG (WCFG),
    .ACK_MODE (ACKM),
    .TIMEOUT  (TMO),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int          wait_of[4] = '{3, 0, 0, 15};
  bit          ack_of[4]  = '{0, 0, 1, 0};
  logic [31:0] rd_of[4]   = '{32'h0BAD0000,
                              32'h12345678,
                              32'hCAFEF00D,
                              32'h33333333};

  typedef struct {
    logic        ready;
    logic        err;
    logic [3:0]  nce;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  int          checks  = 0;
  int          passes  = 0;
  int          cyc     = 0;
  int          last_rdy = -1;
  int          t0;

  task automatic push(input bit rdy, input bit er,
                      input bit act, input int idx,
                      input bit re, input bit we);
    exp_t x;
    x.ready = rdy;
    x.err   = er;
    x.nce   = 4'hF;
    if (act) x.nce[idx] = 1'b0;
    x.re    = act & re;
    x.we    = act & we;
    x.addr  = m_addr;
    x.wdata = m_wdata;
    x.rdata = m_rdata;
    exp_q.push_back(x);
  endtask

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h want %h",
                  name, got, want);
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.cpu_ready === 1'b1) last_rdy = cyc;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.s_nce === e.nce && bus.s_re === e.re
          && bus.s_we === e.we
          && bus.s_addr === e.addr
          && bus.s_wdata === e.wdata
          && bus.cpu_ready === e.ready
          && bus.cpu_rdata === e.rdata
          && (!e.ready || bus.cpu_err === e.err))
        passes++;
      else
        $display({"FAIL cyc%0d model: got nce=%h re=%b",
                  " we=%b rdy=%b err=%b a=%h wd=%h",
                  " rd=%h; want nce=%h re=%b we=%b",
                  " rdy=%b err=%b a=%h wd=%h rd=%h"},
                 cyc, bus.s_nce, bus.s_re, bus.s_we,
                 bus.cpu_ready, bus.cpu_err,
                 bus.s_addr, bus.s_wdata,
                 bus.cpu_rdata, e.nce, e.re, e.we,
                 e.ready, e.err, e.addr, e.wdata,
                 e.rdata);
    end
  end

  // One transaction; ack_at = ACCESS cycle that sees
  // the ack (-1 none); abort>0 stops after that many steps.
  task automatic txn(input bit re, input bit we,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input int ack_at, input int abort,
                     output int ts);
    int idx, n;
    bit bad, err;
    logic [3:0] rnd;
    idx = int'(addr[13:11]);
    bad = (idx >= 4) || (re && we);
    err = 1'b0;
    if (bad) begin
      n = 0;
      err = 1'b1;
    end else if (ack_of[idx]) begin
      if (ack_at >= 0 && ack_at <= int'(TMO))
        n = ack_at + 1;
      else begin
        n = int'(TMO) + 1;
        err = 1'b1;
      end
    end else begin
      n = wait_of[idx] + 1;
    end
    @(negedge clk);
    ts = cyc;
    bus.cpu_re    = re;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.s_ack     = 4'h0;
    m_addr  = addr;
    m_wdata = wdata;
    if (bad) begin
      if (re) m_rdata = 32'hDEADBEEF;
      push(1, 1, 0, 0, re, we);
    end else begin
      push(0, 0, 1, idx, re, we);
    end
    for (int s = 1; s <= n + 1; s++) begin
      if (abort > 0 && s == abort) return;
      @(negedge clk);
      rnd = 4'($urandom);
      if (s <= n) begin
        bus.cpu_re    = rnd[0];
        bus.cpu_we    = rnd[1];
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
      end else begin
        bus.cpu_re = 1'b0;
        bus.cpu_we = 1'b0;
      end
      bus.s_ack = 4'($urandom);
      if (!bad && ack_of[idx])
        bus.s_ack[idx] = (s - 1 == ack_at);
      if (s < n)
        push(0, 0, 1, idx, re, we);
      else if (s == n) begin
        if (re) m_rdata = err ? 32'hDEADBEEF
                              : rd_of[idx];
        push(1, err, 0, 0, re, we);
      end else
        push(0, 0, 0, 0, re, we);
    end
  endtask

  initial begin
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.s_ack     = '0;
    bus.s_rdata   = {rd_of[3], rd_of[2],
                     rd_of[1], rd_of[0]};
    #12;
    check("rst_nce", 32'(bus.s_nce), 32'hF);
    check("rst_re", 32'(bus.s_re), 32'h0);
    check("rst_rdy", 32'(bus.cpu_ready), 32'h0);
    check("rst_rdata", bus.cpu_rdata, 32'h0);
    check("rst_addr", bus.s_addr, 32'h0);
    @(negedge clk);
    nrst = 1'b1;

    txn(1, 0, 32'h0804, 0, -1, 0, t0);
    check("lat_rd1", 32'(last_rdy - t0), 32'd2);
    check("rd1", bus.cpu_rdata, 32'h12345678);

    txn(0, 1, 32'h0, 32'hA5A5A5A5, -1, 0, t0);
    check("lat_wr0", 32'(last_rdy - t0), 32'd5);
    check("wr0_rd", bus.cpu_rdata, 32'h12345678);

    txn(1, 0, 32'h3000, 0, -1, 0, t0);
    check("lat_unmap", 32'(last_rdy - t0), 32'd1);
    check("unmap_rd", bus.cpu_rdata, 32'hDEADBEEF);

    txn(1, 0, 32'h1000, 0, 6, 0, t0);
    check("lat_ack6", 32'(last_rdy - t0), 32'd8);
    check("ack6_rd", bus.cpu_rdata, 32'hCAFEF00D);

    txn(1, 0, 32'h0808, 0, -1, 0, t0);
    txn(0, 1, 32'h1008, 32'h55, -1, 0, t0);
    check("lat_to_wr", 32'(last_rdy - t0), 32'd12);
    check("to_wr_rd", bus.cpu_rdata, 32'h12345678);

    txn(1, 0, 32'h1004, 0, -1, 0, t0);
    check("lat_to_rd", 32'(last_rdy - t0), 32'd12);
    check("to_rd", bus.cpu_rdata, 32'hDEADBEEF);

    txn(1, 1, 32'h0010, 32'h77, -1, 0, t0);
    check("lat_both", 32'(last_rdy - t0), 32'd1);

    txn(1, 0, 32'h1000, 0, 0, 0, t0);
    check("lat_ack0", 32'(last_rdy - t0), 32'd2);

    txn(1, 0, 32'h100C, 0, 10, 0, t0);
    check("lat_ack_to", 32'(last_rdy - t0), 32'd12);

    txn(1, 0, 32'h1800, 0, -1, 4, t0);
    @(negedge clk);
    nrst = 1'b0;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    #1;
    check("abort_nce", 32'(bus.s_nce), 32'hF);
    check("abort_re", 32'(bus.s_re), 32'h0);
    check("abort_rd", bus.cpu_rdata, 32'h0);
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("abort_rdy", 32'(bus.cpu_ready), 32'h0);
    end
    @(negedge clk);
    nrst = 1'b1;

    txn(1, 0, 32'h0804, 0, -1, 0, t0);
    check("lat_post", 32'(last_rdy - t0), 32'd2);
    check("rd_post", bus.cpu_rdata, 32'h12345678);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
